// File: rtl/div_issue_ctrl_if.sv
// Handshake bundle between the divide sequencer and the signed/unsigned divider IPs.
// Operand tdata is shared by both IPs; each IP has its own valid/ready/dout set.
interface div_issue_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0]   dividend_tdata;
  logic [DATA_W-1:0]   divisor_tdata;

  logic                s_dividend_tvalid;
  logic                s_divisor_tvalid;
  logic                s_dividend_tready;
  logic                s_divisor_tready;
  logic                s_dout_tvalid;
  logic [2*DATA_W-1:0] s_dout_tdata;

  logic                u_dividend_tvalid;
  logic                u_divisor_tvalid;
  logic                u_dividend_tready;
  logic                u_divisor_tready;
  logic                u_dout_tvalid;
  logic [2*DATA_W-1:0] u_dout_tdata;

  modport master (
    output dividend_tdata, divisor_tdata,
    output s_dividend_tvalid, s_divisor_tvalid,
    input  s_dividend_tready, s_divisor_tready, s_dout_tvalid, s_dout_tdata,
    output u_dividend_tvalid, u_divisor_tvalid,
    input  u_dividend_tready, u_divisor_tready, u_dout_tvalid, u_dout_tdata
  );

  modport slave (
    input  dividend_tdata, divisor_tdata,
    input  s_dividend_tvalid, s_divisor_tvalid,
    output s_dividend_tready, s_divisor_tready, s_dout_tvalid, s_dout_tdata,
    input  u_dividend_tvalid, u_divisor_tvalid,
    output u_dividend_tready, u_divisor_tready, u_dout_tvalid, u_dout_tdata
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// Issues one EXE divide to the signed or unsigned divider IP and holds the selected
// quotient/remainder until the pipeline takes it; flushed ops drain the IP silently.
module div_issue_ctrl #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_op_req,
  input  logic              i_op_signed,
  input  logic              i_op_rem,
  input  logic [DATA_W-1:0] i_op_dividend,
  input  logic [DATA_W-1:0] i_op_divisor,
  input  logic              i_res_ack,
  input  logic              i_flush,
  output logic              o_res_valid,
  output logic [DATA_W-1:0] o_res_data,
  output logic              o_busy,
  div_issue_ctrl_if.master  ip
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t              r_state,  w_state_nxt;
  logic [DATA_W-1:0]   r_dvd,    w_dvd_nxt;
  logic [DATA_W-1:0]   r_dvs,    w_dvs_nxt;
  logic                r_sel,    w_sel_nxt;
  logic                r_rem,    w_rem_nxt;
  logic                r_kill,   w_kill_nxt;
  logic                r_s_dvd_vld, w_s_dvd_vld_nxt;
  logic                r_s_dvs_vld, w_s_dvs_vld_nxt;
  logic                r_u_dvd_vld, w_u_dvd_vld_nxt;
  logic                r_u_dvs_vld, w_u_dvs_vld_nxt;
  logic [DATA_W-1:0]   r_res_data,  w_res_data_nxt;
  logic                r_res_valid, w_res_valid_nxt;
  logic                r_busy,      w_busy_nxt;

  logic                w_dvd_hs, w_dvs_hs, w_dvd_acc, w_dvs_acc;
  logic                w_dout_v;
  logic [2*DATA_W-1:0] w_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_sel       <= 1'b0;
      r_rem       <= 1'b0;
      r_kill      <= 1'b0;
      r_s_dvd_vld <= 1'b0;
      r_s_dvs_vld <= 1'b0;
      r_u_dvd_vld <= 1'b0;
      r_u_dvs_vld <= 1'b0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dvd       <= w_dvd_nxt;
      r_dvs       <= w_dvs_nxt;
      r_sel       <= w_sel_nxt;
      r_rem       <= w_rem_nxt;
      r_kill      <= w_kill_nxt;
      r_s_dvd_vld <= w_s_dvd_vld_nxt;
      r_s_dvs_vld <= w_s_dvs_vld_nxt;
      r_u_dvd_vld <= w_u_dvd_vld_nxt;
      r_u_dvs_vld <= w_u_dvs_vld_nxt;
      r_res_data  <= w_res_data_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_dvd_nxt       = r_dvd;
    w_dvs_nxt       = r_dvs;
    w_sel_nxt       = r_sel;
    w_rem_nxt       = r_rem;
    w_kill_nxt      = r_kill;
    w_s_dvd_vld_nxt = r_s_dvd_vld;
    w_s_dvs_vld_nxt = r_s_dvs_vld;
    w_u_dvd_vld_nxt = r_u_dvd_vld;
    w_u_dvs_vld_nxt = r_u_dvs_vld;
    w_res_data_nxt  = r_res_data;

    // Only the selected IP ever has a valid raised, so OR-ing both channels is safe.
    w_dvd_hs  = (r_s_dvd_vld & ip.s_dividend_tready) | (r_u_dvd_vld & ip.u_dividend_tready);
    w_dvs_hs  = (r_s_dvs_vld & ip.s_divisor_tready)  | (r_u_dvs_vld & ip.u_divisor_tready);
    w_dvd_acc = ~(r_s_dvd_vld | r_u_dvd_vld) | w_dvd_hs;
    w_dvs_acc = ~(r_s_dvs_vld | r_u_dvs_vld) | w_dvs_hs;
    w_dout_v  = r_sel ? ip.s_dout_tvalid : ip.u_dout_tvalid;
    w_dout    = r_sel ? ip.s_dout_tdata  : ip.u_dout_tdata;

    unique case (r_state)
      S_IDLE: begin
        if (i_op_req && !i_flush) begin
          w_dvd_nxt       = i_op_dividend;
          w_dvs_nxt       = i_op_divisor;
          w_sel_nxt       = i_op_signed;
          w_rem_nxt       = i_op_rem;
          w_kill_nxt      = 1'b0;
          w_s_dvd_vld_nxt = i_op_signed;
          w_s_dvs_vld_nxt = i_op_signed;
          w_u_dvd_vld_nxt = ~i_op_signed;
          w_u_dvs_vld_nxt = ~i_op_signed;
          w_state_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_dvd_hs) begin
          w_s_dvd_vld_nxt = 1'b0;
          w_u_dvd_vld_nxt = 1'b0;
        end
        if (w_dvs_hs) begin
          w_s_dvs_vld_nxt = 1'b0;
          w_u_dvs_vld_nxt = 1'b0;
        end
        if (i_flush) w_kill_nxt = 1'b1;
        if (w_dvd_acc && w_dvs_acc) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_flush) w_kill_nxt = 1'b1;
        // A flush coinciding with dout still cancels the op.
        if (w_dout_v) begin
          if (r_kill || i_flush) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_res_data_nxt = r_rem ? w_dout[DATA_W-1:0] : w_dout[2*DATA_W-1:DATA_W];
            w_state_nxt    = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (i_res_ack || i_flush) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_res_valid_nxt = (w_state_nxt == S_DONE);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
  end

  assign o_res_valid          = r_res_valid;
  assign o_res_data           = r_res_data;
  assign o_busy               = r_busy;
  assign ip.dividend_tdata    = r_dvd;
  assign ip.divisor_tdata     = r_dvs;
  assign ip.s_dividend_tvalid = r_s_dvd_vld;
  assign ip.s_divisor_tvalid  = r_s_dvs_vld;
  assign ip.u_dividend_tvalid = r_u_dvd_vld;
  assign ip.u_divisor_tvalid  = r_u_dvs_vld;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: directed vector table, random ops against a behavioural
// divider/sequencing model, plus a reset-in-flight sequence.
module tb_div_issue_ctrl;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         op_req, op_signed, op_rem, res_ack, flush;
  logic [W-1:0] op_dividend, op_divisor;
  logic         res_valid, busy;
  logic [W-1:0] res_data;

  div_issue_ctrl_if #(.DATA_W(W)) ip_if ();

  div_issue_ctrl #(.DATA_W(W)) dut (
    .clk(clk), .reset(reset),
    .i_op_req(op_req), .i_op_signed(op_signed), .i_op_rem(op_rem),
    .i_op_dividend(op_dividend), .i_op_divisor(op_divisor),
    .i_res_ack(res_ack), .i_flush(flush),
    .o_res_valid(res_valid), .o_res_data(res_data), .o_busy(busy),
    .ip(ip_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic         sgn;
    logic         rem;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           rdv;
    int           rds;
    int           lat;
    int           fl;
    int           hold;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Divider IP behaviour: truncating division, divide-by-zero yields {all ones, dividend}.
  function automatic logic [63:0] ip_model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, q, r;
    if (b == 0) return {32'hFFFF_FFFF, a};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {a, 32'h0};
      sa = a; sb = b;
      q = sa / sb;
      r = sa % sb;
      return {32'(q), 32'(r)};
    end
    return {a / b, a % b};
  endfunction

  // Drive the selected IP's ready/dout; the other IP gets random noise.
  task automatic drive_ip(input logic sgn, input logic rd, input logic rs, input logic dv, input logic [63:0] dd);
    if (sgn) begin
      ip_if.s_dividend_tready = rd; ip_if.s_divisor_tready = rs;
      ip_if.s_dout_tvalid = dv;     ip_if.s_dout_tdata = dd;
      ip_if.u_dividend_tready = 1'($urandom); ip_if.u_divisor_tready = 1'($urandom);
      ip_if.u_dout_tvalid = 1'($urandom);     ip_if.u_dout_tdata = {$urandom, $urandom};
    end else begin
      ip_if.u_dividend_tready = rd; ip_if.u_divisor_tready = rs;
      ip_if.u_dout_tvalid = dv;     ip_if.u_dout_tdata = dd;
      ip_if.s_dividend_tready = 1'($urandom); ip_if.s_divisor_tready = 1'($urandom);
      ip_if.s_dout_tvalid = 1'($urandom);     ip_if.s_dout_tdata = {$urandom, $urandom};
    end
  endtask

  task automatic quiet_ip();
    ip_if.s_dividend_tready = 1'b0; ip_if.s_divisor_tready = 1'b0;
    ip_if.s_dout_tvalid = 1'b0;     ip_if.s_dout_tdata = '0;
    ip_if.u_dividend_tready = 1'b0; ip_if.u_divisor_tready = 1'b0;
    ip_if.u_dout_tvalid = 1'b0;     ip_if.u_dout_tdata = '0;
  endtask

  // One divide: request at cycle 0, each ready rises at cycle rdv/rds, dout lat cycles
  // after the later handshake, optional flush at cycle fl, res_ack after hold cycles.
  task automatic run_op(input vec_t v);
    logic [63:0] dout;
    bit dd, sd, killed, sent;
    int hs, k;
    logic vd, vs, ovd, ovs;
    dout = ip_model(v.sgn, v.a, v.b);
    dd = 0; sd = 0; killed = 0; sent = 0; hs = -1;
    chk("idle_busy", 64'(busy), 64'd0);
    op_req = 1'b1; op_signed = v.sgn; op_rem = v.rem;
    op_dividend = v.a; op_divisor = v.b;
    tick();
    for (k = 1; k <= 100 && !sent; k++) begin
      vd  = v.sgn ? ip_if.s_dividend_tvalid : ip_if.u_dividend_tvalid;
      vs  = v.sgn ? ip_if.s_divisor_tvalid  : ip_if.u_divisor_tvalid;
      ovd = v.sgn ? ip_if.u_dividend_tvalid : ip_if.s_dividend_tvalid;
      ovs = v.sgn ? ip_if.u_divisor_tvalid  : ip_if.s_divisor_tvalid;
      chk("dvd_tvalid", 64'(vd), 64'(!dd));
      chk("dvs_tvalid", 64'(vs), 64'(!sd));
      chk("other_tvalid", 64'({ovd, ovs}), 64'd0);
      if (!(dd && sd)) begin
        chk("dvd_tdata", 64'(ip_if.dividend_tdata), 64'(v.a));
        chk("dvs_tdata", 64'(ip_if.divisor_tdata), 64'(v.b));
      end
      chk("busy_run", 64'(busy), 64'd1);
      chk("res_valid_run", 64'(res_valid), 64'd0);
      // Operands and requests while busy must be ignored.
      op_req = 1'($urandom); op_signed = 1'($urandom); op_rem = 1'($urandom);
      op_dividend = $urandom; op_divisor = $urandom;
      flush = (k == v.fl);
      if (flush) killed = 1;
      sent = (hs >= 0 && k == hs + v.lat);
      drive_ip(v.sgn, k >= v.rdv, k >= v.rds, sent, dout);
      tick();
      if (k >= v.rdv) dd = 1;
      if (k >= v.rds) sd = 1;
      if (dd && sd && hs < 0) hs = k;
    end
    if (!sent) begin
      n_cmp++; n_err++;
      $display("FAIL op_timeout: got no dout after %0d cycles required completion", k);
    end
    op_req = 1'b0; flush = 1'b0;
    quiet_ip();
    if (killed) begin
      chk("kill_busy", 64'(busy), 64'd0);
      chk("kill_res_valid", 64'(res_valid), 64'd0);
    end else begin
      for (int h = 0; h <= v.hold; h++) begin
        chk("res_valid", 64'(res_valid), 64'd1);
        chk("res_data", 64'(res_data), 64'(v.rem ? dout[31:0] : dout[63:32]));
        chk("res_exp", 64'(res_data), 64'(v.exp));
        chk("busy_done", 64'(busy), 64'd1);
        res_ack = (h == v.hold);
        op_req = res_ack ? 1'b1 : 1'($urandom);
        tick();
      end
      res_ack = 1'b0;
      chk("ack_busy", 64'(busy), 64'd0);
      chk("ack_res_valid", 64'(res_valid), 64'd0);
      op_req = 1'b0;
    end
  endtask

  initial begin
    vec_t rv;
    int   mx;
    reset = 1'b1; op_req = 0; op_signed = 0; op_rem = 0; res_ack = 0; flush = 0;
    op_dividend = '0; op_divisor = '0;
    quiet_ip();
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_tvalids", 64'({ip_if.s_dividend_tvalid, ip_if.s_divisor_tvalid,
                            ip_if.u_dividend_tvalid, ip_if.u_divisor_tvalid}), 64'd0);
    chk("rst_tdata", {ip_if.dividend_tdata, ip_if.divisor_tdata}, 64'd0);

    //           sgn  rem  a             b             rdv rds lat fl hold exp
    vecs[0] = '{1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2,        1,  1,  5,  0, 2, 32'hFFFF_FFFD};
    vecs[1] = '{1'b0, 1'b1, 32'd100,       32'd7,        1,  1,  3,  0, 0, 32'd2};
    vecs[2] = '{1'b1, 1'b0, 32'h1234_5678, 32'h10,       3,  6,  2,  0, 1, 32'h0123_4567};
    vecs[3] = '{1'b0, 1'b0, 32'd99,        32'd3,        1,  1,  4,  3, 0, 32'd33};
    vecs[4] = '{1'b0, 1'b0, 32'd50,        32'd5,        1,  1,  2,  0, 0, 32'd10};
    vecs[5] = '{1'b1, 1'b1, 32'd77,        32'd10,       4,  5,  3,  2, 0, 32'd7};
    vecs[6] = '{1'b0, 1'b1, 32'h55,        32'd0,        2,  1,  1,  0, 0, 32'h55};
    foreach (vecs[i]) run_op(vecs[i]);

    for (int n = 0; n < 40; n++) begin
      rv.sgn = 1'($urandom); rv.rem = 1'($urandom);
      rv.a = $urandom; rv.b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      rv.rdv = $urandom_range(1, 4); rv.rds = $urandom_range(1, 4);
      rv.lat = $urandom_range(1, 6); rv.hold = $urandom_range(0, 3);
      mx = (rv.rdv > rv.rds) ? rv.rdv : rv.rds;
      rv.fl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, mx + rv.lat) : 0;
      rv.exp = rv.rem ? ip_model(rv.sgn, rv.a, rv.b) >> 0 : ip_model(rv.sgn, rv.a, rv.b) >> 32;
      run_op(rv);
    end

    // Reset while waiting on the signed IP, then a stale dout two cycles later.
    op_req = 1'b1; op_signed = 1'b1; op_rem = 1'b0;
    op_dividend = 32'd1000; op_divisor = 32'd3;
    tick();
    op_req = 1'b0;
    ip_if.s_dividend_tready = 1'b1; ip_if.s_divisor_tready = 1'b1;
    tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_res_data", 64'(res_data), 64'd0);
    chk("midrst_tdata", {ip_if.dividend_tdata, ip_if.divisor_tdata}, 64'd0);
    tick();
    ip_if.s_dout_tvalid = 1'b1; ip_if.s_dout_tdata = {32'd333, 32'd1};
    tick();
    quiet_ip();
    chk("stale_res_valid", 64'(res_valid), 64'd0);
    chk("stale_busy", 64'(busy), 64'd0);
    chk("stale_tvalids", 64'({ip_if.s_dividend_tvalid, ip_if.s_divisor_tvalid,
                              ip_if.u_dividend_tvalid, ip_if.u_divisor_tvalid}), 64'd0);
    tick();
    chk("stale_res_valid2", 64'(res_valid), 64'd0);
    chk("stale_res_data", 64'(res_data), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Sequences the two AXI-stream divider IPs (signed and unsigned) used by the EXE stage.
- Accepts one divide request from EXE and captures its operands. Drives the IP input handshakes, waits for the IP output, latches the selected quotient or remainder, and holds it until the pipeline consumes it.
- Handles pipeline flush while a divide is in flight: the IP transaction still completes and its result is discarded.

Parameters:
- DATA_W, 32, operand and result width; IP dout width is 2*DATA_W.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- op_req  in  1  EXE holds a valid div/mod instruction (level)
- op_signed  in  1  1 selects the signed IP, 0 the unsigned IP
- op_rem  in  1  1 returns the remainder, 0 the quotient
- op_dividend  in  DATA_W  dividend (alu_src1)
- op_divisor  in  DATA_W  divisor (alu_src2)
- res_ack  in  1  instruction leaves EXE (es_ready_go && ms_allowin)
- flush  in  1  cancel the current instruction
- res_valid  out  1  result available (drives es_ready_go)
- res_data  out  DATA_W  latched result
- busy  out  1  state != IDLE
- dividend_tdata  out  DATA_W  captured dividend, shared by both IPs
- divisor_tdata  out  DATA_W  captured divisor, shared by both IPs
- s_dividend_tvalid, s_divisor_tvalid  out  1 each  signed IP input valids
- s_dividend_tready, s_divisor_tready  in  1 each  signed IP input readies
- s_dout_tvalid  in  1  signed IP result valid
- s_dout_tdata  in  2*DATA_W  signed IP result: quotient [2W-1:W], remainder [W-1:0]
- u_dividend_tvalid, u_divisor_tvalid, u_dividend_tready, u_divisor_tready, u_dout_tvalid, u_dout_tdata  same roles for the unsigned IP

Behaviour:
- Reset values:
  - State IDLE.
  - All tvalid outputs 0; res_valid 0; busy 0.
  - res_data, tdata and the sel/rem/kill registers 0.
  - Reset mid-operation abandons the transaction. Any later dout_tvalid arriving while in IDLE is ignored.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - op_req=1 and flush=0 → capture dividend, divisor, op_signed (sel) and op_rem; kill=0; go to ISSUE.
  - Both tvalids of the selected IP rise in the next cycle. The other IP's tvalids stay 0.
  - op_req and flush both high: flush wins, no capture.
- ISSUE:
  - Dividend and divisor channels are independent.
  - Each tvalid stays high until its own tready is sampled high with tvalid high, then drops next cycle and stays 0.
  - A channel's "accepted" flag is set on its handshake.
  - Both accepted (including both in the same cycle) → WAIT.
  - tvalid is never withdrawn before its handshake, even on flush.
  - tdata is stable from capture until both handshakes complete.
- WAIT:
  - On the selected IP's dout_tvalid: if kill=0, latch res_data = op_rem ? dout[W-1:0] : dout[2W-1:W] and go to DONE.
  - If kill=1, go to IDLE with res_valid staying 0.
  - The unselected IP's dout_tvalid is ignored.
- DONE:
  - res_valid=1 and res_data held.
  - res_ack → IDLE. An op_req in that same cycle is not captured; capture happens at the earliest in the next cycle.
  - flush → IDLE, result discarded.
- Flush in ISSUE or WAIT: kill is set, and the state machine keeps running until dout returns.
  - res_valid is never asserted for a killed op.
  - busy stays 1 until IDLE.
- op_req is ignored outside IDLE. Operand changes after capture have no effect.
- Latency:
  - op_req sampled at cycle N → tvalid high at N+1.
  - Zero-wait readies → WAIT at N+2.
  - dout_tvalid at cycle M → res_valid at M+1.
- Divisor = 0 is passed to the IP unchanged; the IP's output is returned as-is.
- Signed/unsigned interpretation is done by the IPs. No arithmetic on data in this block beyond the quotient/remainder half-select.

Test Plan:
- Signed div, dividend 0xFFFFFFF9 (-7), divisor 2; IP model with readies always 1, 5-cycle latency, dout {0xFFFFFFFD, 0xFFFFFFFF} → s_*_tvalid high exactly 1 cycle, u_* tvalids stay 0, res_valid at issue+7, res_data 0xFFFFFFFD, held until res_ack.
- Unsigned mod, dividend 100, divisor 7, op_rem=1 → u_* handshake only, res_data 0x00000002; res_ack → busy 0 next cycle.
- Skewed readies: dividend tready at cycle 3, divisor tready at cycle 6 → each tvalid drops 1 cycle after its own handshake, tdata constant throughout, WAIT entered at cycle 7.
- Flush during WAIT, then dout arrives → res_valid never 1; state returns to IDLE; a new op_req the following cycle issues normally with correct result.
- Flush in ISSUE before any tready → tvalids held until handshake, result discarded, busy clears after dout_tvalid.
- Reset asserted in WAIT, stale dout_tvalid 2 cycles later → outputs stay at reset values, no res_valid.
